// File: rtl/cache_miss_handler.sv
// Miss handler between the cache and backing memory: optional dirty-victim
// writeback, then an in-order line fill, then a one-cycle done with the critical word.
module cache_miss_handler #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFFSET_W       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                miss_valid,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic                miss_dirty,
    input  logic [ADDR_W-1:0]   victim_addr,
    output logic                miss_ready,
    output logic [OFFSET_W-1:0] victim_rd_idx,
    input  logic [DATA_W-1:0]   victim_rd_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                fill_we,
    output logic [ADDR_W-1:0]   fill_addr,
    output logic [DATA_W-1:0]   fill_data,
    output logic                done,
    output logic [DATA_W-1:0]   done_data
);

    localparam int TAG_W = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] k_q, k_d;
    logic [OFFSET_W-1:0] crit_off_q, crit_off_d;
    logic [TAG_W-1:0]    line_hi_q, line_hi_d;
    logic [TAG_W-1:0]    victim_hi_q, victim_hi_d;
    logic                fill_we_q, fill_we_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]   fill_data_q, fill_data_d;
    logic [DATA_W-1:0]   done_data_q, done_data_d;
    logic                last_word;

    assign last_word = (k_q == OFFSET_W'(WORDS_PER_LINE - 1));

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        crit_off_d  = crit_off_q;
        line_hi_d   = line_hi_q;
        victim_hi_d = victim_hi_q;
        fill_we_d   = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        done_data_d = done_data_q;
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    line_hi_d   = miss_addr[ADDR_W-1:OFFSET_W];
                    crit_off_d  = miss_addr[OFFSET_W-1:0];
                    victim_hi_d = victim_addr[ADDR_W-1:OFFSET_W];
                    k_d         = '0;
                    state_d     = miss_dirty ? WB : FILL;
                end
            end
            WB: begin
                // k wraps to 0 on the last ack since the line size is a power of two
                if (mem_ack) begin
                    k_d = k_q + OFFSET_W'(1);
                    if (last_word) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fill_we_d   = 1'b1;
                    fill_addr_d = {line_hi_q, k_q};
                    fill_data_d = mem_rdata;
                    if (k_q == crit_off_q) begin
                        done_data_d = mem_rdata;
                    end
                    k_d = k_q + OFFSET_W'(1);
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            crit_off_q  <= '0;
            line_hi_q   <= '0;
            victim_hi_q <= '0;
            fill_we_q   <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            crit_off_q  <= crit_off_d;
            line_hi_q   <= line_hi_d;
            victim_hi_q <= victim_hi_d;
            fill_we_q   <= fill_we_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            done_data_q <= done_data_d;
        end
    end

    // Request fields are decoded from state, so they hold steady until the ack
    always_comb begin
        miss_ready    = (state_q == IDLE);
        mem_req       = (state_q == WB) || (state_q == FILL);
        mem_we        = (state_q == WB);
        mem_addr      = '0;
        mem_wdata     = '0;
        victim_rd_idx = '0;
        if (state_q == WB) begin
            mem_addr      = {victim_hi_q, k_q};
            mem_wdata     = victim_rd_data;
            victim_rd_idx = k_q;
        end else if (state_q == FILL) begin
            mem_addr = {line_hi_q, k_q};
        end
        done      = (state_q == DONE);
        fill_we   = fill_we_q;
        fill_addr = fill_addr_q;
        fill_data = fill_data_q;
        done_data = done_data_q;
    end

endmodule
